block_period_scheduler: RTL and testbench

Registered, back-pressure-aware scheduler that merges the four detector-block event streams and the time-tag stream into one 128-bit output stream for the frontend packetizer. Events from a block are emitted before a pending time tag only if their period precedes it. Blocks eligible in the same cycle share the output by round-robin instead of fixed priority. The block keeps late-event and time-tag counters for the frontend status registers.

---
 rtl/block_period_scheduler_if.sv | 34 +++
 rtl/block_period_scheduler.sv | 120 ++++++++++++
 tb/tb_block_period_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/block_period_scheduler_if.sv
// block_period_scheduler_if
// Bundles the four detector-block event streams, the time-tag stream and the
// merged output stream of block_period_scheduler.
//   blk_valid/blk_period/blk_data/blk_ready : per-block event streams, block i
//                                              packed at [i*W +: W]
//   tt_valid/tt_period/tt_data/tt_ready     : time-tag stream
//   out_valid/out_data/out_ready            : merged output stream
// slave  = scheduler side, master = environment side.
interface block_period_scheduler_if #(
    parameter int DATA_W   = 128,
    parameter int PERIOD_W = 48
);
    logic [3:0]            blk_valid;
    logic [4*PERIOD_W-1:0] blk_period;
    logic [4*DATA_W-1:0]   blk_data;
    logic [3:0]            blk_ready;
    logic                  tt_valid;
    logic [PERIOD_W-1:0]   tt_period;
    logic [DATA_W-1:0]     tt_data;
    logic                  tt_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  out_ready;

    modport slave (
        input  blk_valid, blk_period, blk_data, tt_valid, tt_period, tt_data, out_ready,
        output blk_ready, tt_ready, out_valid, out_data
    );

    modport master (
        output blk_valid, blk_period, blk_data, tt_valid, tt_period, tt_data, out_ready,
        input  blk_ready, tt_ready, out_valid, out_data
    );
endinterface

// File: rtl/block_period_scheduler.sv
// block_period_scheduler
// Merges four detector-block event streams and the time-tag stream into one
// registered output stream. A block event goes ahead of a pending time tag only
// when its period is strictly earlier; competing blocks share the output by
// round-robin. Keeps a saturating late-event counter and a wrapping time-tag
// counter.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : event/time-tag inputs and merged output (slave modport)
//   late_count : saturating count of events emitted behind the last time tag
//   tt_count   : wrapping count of emitted time tags
module block_period_scheduler #(
    parameter int DATA_W   = 128,
    parameter int PERIOD_W = 48,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    block_period_scheduler_if.slave  bus,
    output logic [CNT_W-1:0]         late_count,
    output logic [CNT_W-1:0]         tt_count
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [PERIOD_W-1:0] last_tt_period_q, last_tt_period_d;
    logic [CNT_W-1:0]    late_count_q, late_count_d;
    logic [CNT_W-1:0]    tt_count_q, tt_count_d;

    logic [PERIOD_W-1:0] period_a [4];
    logic [DATA_W-1:0]   data_a [4];
    logic [3:0]          elig;
    logic                load;
    logic                blk_gnt;
    logic                tt_gnt;
    logic [1:0]          gnt_idx;
    logic [1:0]          scan_idx;
    logic [3:0]          blk_ready_c;
    logic                tt_ready_c;

    always_comb begin
        load = ~out_valid_q | bus.out_ready;

        for (int i = 0; i < 4; i++) begin
            period_a[i] = bus.blk_period[i*PERIOD_W +: PERIOD_W];
            data_a[i]   = bus.blk_data[i*DATA_W +: DATA_W];
            // Equal periods lose to the time tag, hence strict less-than.
            elig[i]     = bus.blk_valid[i] & (~bus.tt_valid | (period_a[i] < bus.tt_period));
        end

        // Scan downward from the farthest offset so the nearest eligible
        // block at or after rr_ptr wins.
        blk_gnt  = 1'b0;
        gnt_idx  = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (elig[scan_idx]) begin
                blk_gnt = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        tt_gnt = ~blk_gnt & bus.tt_valid;

        blk_ready_c = (load & ~rst & blk_gnt) ? (4'b0001 << gnt_idx) : 4'b0000;
        tt_ready_c  = load & ~rst & tt_gnt;

        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        rr_ptr_d         = rr_ptr_q;
        last_tt_period_d = last_tt_period_q;
        late_count_d     = late_count_q;
        tt_count_d       = tt_count_q;

        if (load) begin
            if (blk_gnt) begin
                out_valid_d = 1'b1;
                out_data_d  = data_a[gnt_idx];
                rr_ptr_d    = gnt_idx + 2'd1;
                if ((period_a[gnt_idx] < last_tt_period_q) && (late_count_q != '1)) begin
                    late_count_d = late_count_q + CNT_W'(1);
                end
            end else if (tt_gnt) begin
                out_valid_d      = 1'b1;
                out_data_d       = bus.tt_data;
                last_tt_period_d = bus.tt_period;
                tt_count_d       = tt_count_q + CNT_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            rr_ptr_q         <= 2'd0;
            last_tt_period_q <= '0;
            late_count_q     <= '0;
            tt_count_q       <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            rr_ptr_q         <= rr_ptr_d;
            last_tt_period_q <= last_tt_period_d;
            late_count_q     <= late_count_d;
            tt_count_q       <= tt_count_d;
        end
    end

    assign bus.blk_ready = blk_ready_c;
    assign bus.tt_ready  = tt_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign late_count    = late_count_q;
    assign tt_count      = tt_count_q;

endmodule

// File: tb/tb_block_period_scheduler.sv
module tb_block_period_scheduler;

    localparam int DATA_W   = 128;
    localparam int PERIOD_W = 48;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [CNT_W-1:0] late_count, tt_count;

    always #5 clk = ~clk;

    block_period_scheduler_if #(.DATA_W(DATA_W), .PERIOD_W(PERIOD_W)) bus ();

    block_period_scheduler #(.DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .late_count (late_count),
        .tt_count   (tt_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the current cycle.
    logic                tb_rst;
    logic [3:0]          tb_bv;
    logic [PERIOD_W-1:0] tb_p [4];
    logic                tb_tv;
    logic [PERIOD_W-1:0] tb_tp;
    logic                tb_ordy;

    // Reference model state.
    logic                m_ov;
    logic [DATA_W-1:0]   m_od;
    int                  m_rr;
    logic [PERIOD_W-1:0] m_last;
    int                  m_late;
    int                  m_ttc;

    logic [4:0] cap_rdy;

    function automatic logic [DATA_W-1:0] mkdata(input int src, input logic [PERIOD_W-1:0] p);
        return {8'(src), 72'h5a5a_0000_0000_0000_00, p};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check readies against the model, clock, check outputs.
    task automatic step();
        int src;
        int best;
        logic load;
        logic [4:0] exp_rdy;
        @(negedge clk);
        rst           = tb_rst;
        bus.blk_valid = tb_bv;
        for (int i = 0; i < 4; i++) begin
            bus.blk_period[i*PERIOD_W +: PERIOD_W] = tb_p[i];
            bus.blk_data[i*DATA_W +: DATA_W]       = mkdata(i + 1, tb_p[i]);
        end
        bus.tt_valid  = tb_tv;
        bus.tt_period = tb_tp;
        bus.tt_data   = mkdata(5, tb_tp);
        bus.out_ready = tb_ordy;
        #1;

        // Pick the eligible block closest to the round-robin pointer.
        src  = 0;
        best = 99;
        for (int i = 0; i < 4; i++) begin
            if (tb_bv[i] && (!tb_tv || tb_p[i] < tb_tp)) begin
                if (((i - m_rr + 4) % 4) < best) begin
                    best = (i - m_rr + 4) % 4;
                    src  = i + 1;
                end
            end
        end
        if (src == 0 && tb_tv) src = 5;
        load = !m_ov || tb_ordy;

        exp_rdy = 5'b0;
        if (!tb_rst && load && src != 0) exp_rdy[src - 1] = 1'b1;
        cap_rdy = {bus.tt_ready, bus.blk_ready};
        check("ready", DATA_W'(cap_rdy), DATA_W'(exp_rdy));

        @(posedge clk);
        #1;
        if (tb_rst) begin
            m_ov = 0; m_od = '0; m_rr = 0; m_last = '0; m_late = 0; m_ttc = 0;
        end else if (load) begin
            if (src >= 1 && src <= 4) begin
                m_ov = 1;
                m_od = mkdata(src, tb_p[src - 1]);
                m_rr = src % 4;
                if (tb_p[src - 1] < m_last && m_late < CNT_MAX) m_late++;
            end else if (src == 5) begin
                m_ov   = 1;
                m_od   = mkdata(5, tb_tp);
                m_last = tb_tp;
                m_ttc  = (m_ttc + 1) % (CNT_MAX + 1);
            end else begin
                m_ov = 0;
            end
        end
        check("out_valid", DATA_W'(bus.out_valid), DATA_W'(m_ov));
        check("out_data", bus.out_data, m_od);
        check("late_count", DATA_W'(late_count), DATA_W'(m_late));
        check("tt_count", DATA_W'(tt_count), DATA_W'(m_ttc));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] bv;
        int         p0, p1, p2, p3;
        logic       tv;
        int         tp;
        logic       ordy;
        logic [4:0] exp_rdy;
        logic       exp_ov;
        logic [DATA_W-1:0] exp_data;
        int         exp_late;
        int         exp_ttc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] bv, input int p0, input int p1,
                       input int p2, input int p3, input logic tv, input int tp,
                       input logic ordy, input logic [4:0] erdy, input logic eov,
                       input logic [DATA_W-1:0] ed, input int el, input int et);
        vec_t v;
        v.rst = r; v.bv = bv; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.tv = tv; v.tp = tp; v.ordy = ordy; v.exp_rdy = erdy; v.exp_ov = eov;
        v.exp_data = ed; v.exp_late = el; v.exp_ttc = et;
        vq.push_back(v);
    endtask

    initial begin
        int blk;
        rst = 1'b1;
        bus.blk_valid = '0; bus.blk_period = '0; bus.blk_data = '0;
        bus.tt_valid = 1'b0; bus.tt_period = '0; bus.tt_data = '0; bus.out_ready = 1'b1;
        m_ov = 0; m_od = '0; m_rr = 0; m_last = '0; m_late = 0; m_ttc = 0;

        // Readies are {tt, blk4, blk3, blk2, blk1}.
        add(1, 4'b1111, 3, 3, 3, 3, 1, 100, 1, 5'b00000, 0, '0, 0, 0);
        add(0, 4'b0010, 0, 5, 0, 0, 0, 0,   1, 5'b00010, 1, mkdata(2, 5), 0, 0);
        add(1, 4'b0000, 0, 0, 0, 0, 0, 0,   1, 5'b00000, 0, '0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 4'b1111, 3, 3, 3, 3, 0, 0, 1, 5'(1 << (k % 4)), 1, mkdata(k % 4 + 1, 3), 0, 0);
        add(0, 4'b0101, 9, 0, 10, 0, 1, 10, 1, 5'b00001, 1, mkdata(1, 9), 0, 0);
        add(0, 4'b0100, 0, 0, 10, 0, 1, 10, 1, 5'b10000, 1, mkdata(5, 10), 0, 1);
        add(0, 4'b0100, 0, 0, 10, 0, 0, 0,  1, 5'b00100, 1, mkdata(3, 10), 0, 1);
        add(0, 4'b1000, 0, 0, 0, 7,  0, 0,  1, 5'b01000, 1, mkdata(4, 7), 1, 1);
        for (int k = 0; k < 5; k++)
            add(0, 4'b1111, 3, 3, 3, 3, 1, 100, 0, 5'b00000, 1, mkdata(4, 7), 1, 1);
        add(0, 4'b1111, 3, 3, 3, 3, 1, 100, 1, 5'b00001, 1, mkdata(1, 3), 2, 1);
        add(1, 4'b1111, 3, 3, 3, 3, 1, 100, 1, 5'b00000, 0, '0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,   1, 5'b00000, 0, '0, 0, 0);

        foreach (vq[n]) begin
            tb_rst = vq[n].rst; tb_bv = vq[n].bv;
            tb_p[0] = PERIOD_W'(vq[n].p0); tb_p[1] = PERIOD_W'(vq[n].p1);
            tb_p[2] = PERIOD_W'(vq[n].p2); tb_p[3] = PERIOD_W'(vq[n].p3);
            tb_tv = vq[n].tv; tb_tp = PERIOD_W'(vq[n].tp); tb_ordy = vq[n].ordy;
            step();
            check($sformatf("vec%0d_ready", n), DATA_W'(cap_rdy), DATA_W'(vq[n].exp_rdy));
            check($sformatf("vec%0d_valid", n), DATA_W'(bus.out_valid), DATA_W'(vq[n].exp_ov));
            check($sformatf("vec%0d_data", n), bus.out_data, vq[n].exp_data);
            check($sformatf("vec%0d_late", n), DATA_W'(late_count), DATA_W'(vq[n].exp_late));
            check($sformatf("vec%0d_ttc", n), DATA_W'(tt_count), DATA_W'(vq[n].exp_ttc));
        end

        // Late-counter saturation: time tag at 10, then many events at period 7.
        tb_rst = 0; tb_ordy = 1; tb_bv = 4'b0000; tb_tv = 1; tb_tp = 10;
        for (int i = 0; i < 4; i++) tb_p[i] = 7;
        step();
        tb_tv = 0;
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            blk = int'($urandom_range(3, 0));
            tb_bv = 4'(1 << blk);
            step();
        end
        check("late_saturated", DATA_W'(late_count), DATA_W'(CNT_MAX));

        // Time-tag counter wrap: 20 more tags on top of the one above.
        tb_bv = 4'b0000; tb_tv = 1;
        for (int k = 0; k < 20; k++) begin
            tb_tp = PERIOD_W'(20 + k);
            step();
        end
        check("tt_count_wrap", DATA_W'(tt_count), DATA_W'(21 % (CNT_MAX + 1)));

        // Randomized traffic against the model; small period range forces ties.
        for (int k = 0; k < 3000; k++) begin
            tb_rst  = ($urandom_range(127, 0) == 0);
            tb_bv   = 4'($urandom_range(15, 0));
            for (int i = 0; i < 4; i++) tb_p[i] = PERIOD_W'($urandom_range(15, 0));
            tb_tv   = ($urandom_range(2, 0) == 0);
            tb_tp   = PERIOD_W'($urandom_range(15, 0));
            tb_ordy = ($urandom_range(3, 0) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
